// File: rtl/wb_serial_pkg.sv
// rtl/wb_serial_pkg.sv - opcodes, status codes and FSM states for wb_serial_master
package wb_serial_pkg;

    localparam logic [7:0] OP_WRITE   = 8'h01;
    localparam logic [7:0] OP_READ    = 8'h02;

    localparam logic [7:0] ST_OK      = 8'h00;
    localparam logic [7:0] ST_TIMEOUT = 8'hEE;
    localparam logic [7:0] ST_BADOP   = 8'hFF;

    typedef enum logic [2:0] {
        S_IDLE,
        S_ADDR,
        S_DATA,
        S_BUS,
        S_RESP,
        S_RDATA
    } state_t;

endpackage

// File: rtl/wb_serial_master.sv
// rtl/wb_serial_master.sv - byte-stream to classic Wishbone master bridge
// Optional ack watchdog enabled by defining WB_SERIAL_TIMEOUT_EN.
module wb_serial_master
    import wb_serial_pkg::*;
#(
    parameter int AW      = 32,
    parameter int DW      = 32,
    parameter int TIMEOUT = 255
) (
    input  logic          wb_clk_i,
    input  logic          wb_reset_i,
    input  logic [7:0]    rx_data,
    input  logic          rx_valid,
    output logic          rx_get,
    output logic [7:0]    tx_data,
    output logic          tx_valid,
    input  logic          tx_ready,
    output logic [AW-1:0] wb_adr_o,
    output logic [DW-1:0] wb_dat_o,
    input  logic [DW-1:0] wb_dat_i,
    output logic          wb_we_o,
    output logic [DW/8-1:0] wb_sel_o,
    output logic          wb_cyc_o,
    output logic          wb_stb_o,
    input  logic          wb_ack_i
);

    state_t        r_state;
    state_t        w_next;
    logic          r_rx_get;
    logic [1:0]    r_cnt;
    logic          r_is_read;
    logic [7:0]    r_status;
    logic [31:0]   r_adr;
    logic [DW-1:0] r_dat;
    logic [DW-1:0] r_rdata;
    logic          w_rx_state;
    logic          w_expire;

    assign w_rx_state = (r_state == S_IDLE) || (r_state == S_ADDR) || (r_state == S_DATA);
    assign rx_get     = r_rx_get;
    assign wb_adr_o   = r_adr[AW-1:0];
    assign wb_dat_o   = r_dat;
    assign wb_sel_o   = '1;

`ifdef WB_SERIAL_TIMEOUT_EN
    localparam int TW = (TIMEOUT > 255) ? $clog2(TIMEOUT + 1) : 8;
    logic [TW-1:0] r_tmo;

    // Counts BUS cycles without ack; expiry is evaluated on the edge that would reach TIMEOUT.
    always_ff @(posedge wb_clk_i or posedge wb_reset_i) begin
        if (wb_reset_i) begin
            r_tmo <= '0;
        end else if (r_state == S_BUS) begin
            r_tmo <= r_tmo + 1'b1;
        end else begin
            r_tmo <= '0;
        end
    end

    assign w_expire = (r_state == S_BUS) && (r_tmo == TW'(TIMEOUT - 1));
`else
    localparam int unused_timeout = TIMEOUT;
    assign w_expire = 1'b0;
`endif

    always_ff @(posedge wb_clk_i or posedge wb_reset_i) begin
        if (wb_reset_i) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            S_IDLE:  if (r_rx_get) w_next = (rx_data == OP_WRITE || rx_data == OP_READ) ? S_ADDR : S_RESP;
            S_ADDR:  if (r_rx_get && r_cnt == 2'd3) w_next = r_is_read ? S_BUS : S_DATA;
            S_DATA:  if (r_rx_get && r_cnt == 2'd3) w_next = S_BUS;
            S_BUS:   if (wb_ack_i || w_expire) w_next = S_RESP;
            S_RESP:  if (tx_ready) w_next = r_is_read ? S_RDATA : S_IDLE;
            S_RDATA: if (tx_ready && r_cnt == 2'd3) w_next = S_IDLE;
            default: w_next = S_IDLE;
        endcase
    end

    always_comb begin
        wb_cyc_o = 1'b0;
        wb_stb_o = 1'b0;
        wb_we_o  = 1'b0;
        tx_valid = 1'b0;
        tx_data  = 8'h00;
        case (r_state)
            S_BUS: begin
                wb_cyc_o = 1'b1;
                wb_stb_o = 1'b1;
                wb_we_o  = !r_is_read;
            end
            S_RESP: begin
                tx_valid = 1'b1;
                tx_data  = r_status;
            end
            S_RDATA: begin
                tx_valid = 1'b1;
                case (r_cnt)
                    2'd0:    tx_data = r_rdata[7:0];
                    2'd1:    tx_data = r_rdata[15:8];
                    2'd2:    tx_data = r_rdata[23:16];
                    default: tx_data = r_rdata[31:24];
                endcase
            end
            default: ;
        endcase
    end

    // A byte is consumed on the edge where rx_get is high; blocking back-to-back pulses
    // gives the source a cycle to advance rx_valid/rx_data.
    always_ff @(posedge wb_clk_i or posedge wb_reset_i) begin
        if (wb_reset_i) begin
            r_rx_get  <= 1'b0;
            r_cnt     <= 2'd0;
            r_is_read <= 1'b0;
            r_status  <= ST_OK;
            r_adr     <= '0;
            r_dat     <= '0;
            r_rdata   <= '0;
        end else begin
            r_rx_get <= rx_valid && w_rx_state && !r_rx_get;
            case (r_state)
                S_IDLE: begin
                    r_cnt <= 2'd0;
                    if (r_rx_get) begin
                        r_is_read <= (rx_data == OP_READ);
                        if (rx_data != OP_WRITE && rx_data != OP_READ) r_status <= ST_BADOP;
                    end
                end
                S_ADDR: if (r_rx_get) begin
                    r_adr <= {rx_data, r_adr[31:8]};
                    r_cnt <= r_cnt + 2'd1;
                end
                S_DATA: if (r_rx_get) begin
                    r_dat <= {rx_data, r_dat[DW-1:8]};
                    r_cnt <= r_cnt + 2'd1;
                end
                S_BUS: begin
                    if (wb_ack_i) begin
                        r_status <= ST_OK;
                        if (r_is_read) r_rdata <= wb_dat_i;
                    end else if (w_expire) begin
                        r_status <= ST_TIMEOUT;
                        r_rdata  <= '0;
                    end
                end
                S_RDATA: if (tx_ready) r_cnt <= r_cnt + 2'd1;
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_wb_serial_master.sv
// tb/tb_wb_serial_master.sv - directed self-checking bench for wb_serial_master
module tb_wb_serial_master;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [7:0]  rx_data = 8'h00;
    logic        rx_valid = 1'b0;
    logic        rx_get;
    logic [7:0]  tx_data;
    logic        tx_valid;
    logic        tx_ready = 1'b1;
    logic [31:0] wb_adr_o;
    logic [31:0] wb_dat_o;
    logic [31:0] wb_dat_i = 32'h0;
    logic        wb_we_o;
    logic [3:0]  wb_sel_o;
    logic        wb_cyc_o;
    logic        wb_stb_o;
    logic        wb_ack_i = 1'b0;

    always #5 clk = ~clk;

    wb_serial_master #(.AW(32), .DW(32), .TIMEOUT(16)) dut (
        .wb_clk_i(clk), .wb_reset_i(rst),
        .rx_data(rx_data), .rx_valid(rx_valid), .rx_get(rx_get),
        .tx_data(tx_data), .tx_valid(tx_valid), .tx_ready(tx_ready),
        .wb_adr_o(wb_adr_o), .wb_dat_o(wb_dat_o), .wb_dat_i(wb_dat_i),
        .wb_we_o(wb_we_o), .wb_sel_o(wb_sel_o), .wb_cyc_o(wb_cyc_o),
        .wb_stb_o(wb_stb_o), .wb_ack_i(wb_ack_i)
    );

    int checks = 0;
    int errors = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    // Host-to-device byte source
    logic [7:0] src_mem [256];
    int src_wr = 0;
    int src_rd = 0;

    always @(negedge clk) begin
        rx_valid = (src_rd != src_wr);
        rx_data  = rx_valid ? src_mem[src_rd % 256] : 8'h00;
    end
    always @(posedge clk) if (rx_get && src_rd != src_wr) src_rd++;

    task automatic send(input logic [7:0] b);
        src_mem[src_wr % 256] = b;
        src_wr++;
    endtask

    // Wishbone slave model
    int          ws = 0;
    bit          never_ack = 0;
    logic [31:0] sl_rdata = 32'h0;
    logic [31:0] sl_adr, sl_dat;
    logic        sl_we;
    logic [3:0]  sl_sel;
    int          sl_cnt = 0;
    int          stb_total = 0;
    int          stab_err = 0;

    always @(negedge clk) begin
        if (wb_cyc_o && wb_stb_o) begin
            if (sl_cnt == 0) begin
                sl_adr = wb_adr_o; sl_dat = wb_dat_o; sl_we = wb_we_o; sl_sel = wb_sel_o;
            end else if (wb_adr_o !== sl_adr || wb_dat_o !== sl_dat || wb_we_o !== sl_we) begin
                stab_err++;
            end
            wb_ack_i = !never_ack && (sl_cnt == ws);
            wb_dat_i = wb_ack_i ? sl_rdata : 32'h0;
            sl_cnt++;
            stb_total++;
        end else begin
            wb_ack_i = 1'b0;
            sl_cnt   = 0;
        end
    end

    // Device-to-host sink with optional backpressure pattern
    logic [7:0] rsp_mem [256];
    int   rsp_n = 0;
    int   acc_n = 0;
    int   last_acc = 0;
    int   tx_mode = 0;
    int   bp_cyc = 0;
    logic last_valid = 1'b0;
    logic [7:0] last_tx = 8'h00;
    int   tx_stab_err = 0;

    always @(posedge clk) begin
        if (tx_valid && tx_ready) begin
            rsp_mem[rsp_n % 256] = tx_data;
            rsp_n++;
            acc_n++;
        end
    end

    always @(negedge clk) begin
        if (tx_valid && last_valid && acc_n == last_acc && tx_data !== last_tx) tx_stab_err++;
        last_valid = tx_valid;
        last_tx    = tx_data;
        last_acc   = acc_n;
        if (tx_mode == 0) begin
            tx_ready = 1'b1;
        end else begin
            if (tx_valid || bp_cyc > 0) bp_cyc++;
            tx_ready = (bp_cyc < 8) ? bp_cyc[0] : (bp_cyc >= 28);
        end
    end

    int rsp_base = 0;
    int stb_base = 0;

    task automatic start_test();
        rsp_base = rsp_n;
        stb_base = stb_total;
    endtask

    task automatic wait_resp(input string tag, input int n);
        for (int i = 0; i < 500 && (rsp_n - rsp_base) < n; i++) @(negedge clk);
        repeat (8) @(negedge clk);
        check({tag, "_nresp"}, rsp_n - rsp_base, n);
    endtask

    function automatic logic [7:0] rb(input int i);
        return (rsp_base + i < rsp_n) ? rsp_mem[(rsp_base + i) % 256] : 8'hxx;
    endfunction

    initial begin
        repeat (3) @(negedge clk);
        check("rst_cyc", wb_cyc_o, 0);
        check("rst_txv", tx_valid, 0);
        check("rst_rxget", rx_get, 0);
        check("rst_adr", wb_adr_o, 0);
        rst = 1'b0;
        repeat (2) @(negedge clk);

        // Zero-wait-state write
        start_test();
        ws = 0;
        send(8'h01); send(8'h10); send(8'h00); send(8'h00); send(8'h00);
        send(8'hEF); send(8'hBE); send(8'hAD); send(8'hDE);
        wait_resp("wr", 1);
        check("wr_status", rb(0), 8'h00);
        check("wr_stb_cycles", stb_total - stb_base, 1);
        check("wr_adr", sl_adr, 32'h0000_0010);
        check("wr_dat", sl_dat, 32'hDEAD_BEEF);
        check("wr_we", sl_we, 1);
        check("wr_sel", sl_sel, 4'hF);

        // Read with 3 wait states
        start_test();
        ws = 3; sl_rdata = 32'h1234_5678;
        send(8'h02); send(8'h04); send(8'h00); send(8'h00); send(8'h00);
        wait_resp("rd", 5);
        check("rd_stb_cycles", stb_total - stb_base, 4);
        check("rd_we", sl_we, 0);
        check("rd_adr", sl_adr, 32'h0000_0004);
        check("rd_b0", rb(0), 8'h00);
        check("rd_b1", rb(1), 8'h78);
        check("rd_b2", rb(2), 8'h56);
        check("rd_b3", rb(3), 8'h34);
        check("rd_b4", rb(4), 8'h12);

        // Bad opcode, then a normal write
        start_test();
        send(8'h7A);
        wait_resp("bad", 1);
        check("bad_status", rb(0), 8'hFF);
        check("bad_no_bus", stb_total - stb_base, 0);
        start_test();
        ws = 0;
        send(8'h01); send(8'h20); send(8'h00); send(8'h00); send(8'h00);
        send(8'h44); send(8'h33); send(8'h22); send(8'h11);
        wait_resp("wr2", 1);
        check("wr2_status", rb(0), 8'h00);
        check("wr2_adr", sl_adr, 32'h0000_0020);
        check("wr2_dat", sl_dat, 32'h1122_3344);

        // Read under toggling and then long-held backpressure
        start_test();
        ws = 2; sl_rdata = 32'hA1B2_C3D4; tx_mode = 1;
        send(8'h02); send(8'h30); send(8'h00); send(8'h00); send(8'h00);
        wait_resp("bp", 5);
        check("bp_b0", rb(0), 8'h00);
        check("bp_b1", rb(1), 8'hD4);
        check("bp_b2", rb(2), 8'hC3);
        check("bp_b3", rb(3), 8'hB2);
        check("bp_b4", rb(4), 8'hA1);
        check("bp_tx_stable", tx_stab_err, 0);
        tx_mode = 0;

        // Asynchronous reset after A1 of a write
        start_test();
        send(8'h01); send(8'h55); send(8'h66);
        for (int i = 0; i < 100 && src_rd != src_wr; i++) @(negedge clk);
        repeat (2) @(negedge clk);
        check("mid_adr_pre", wb_adr_o, 32'h6655_0000);
        #2 rst = 1'b1;
        #1;
        check("mid_adr", wb_adr_o, 0);
        check("mid_dat", wb_dat_o, 0);
        check("mid_rxget", rx_get, 0);
        check("mid_txv", tx_valid, 0);
        check("mid_txd", tx_data, 0);
        check("mid_cyc", {wb_cyc_o, wb_stb_o, wb_we_o}, 0);
        @(negedge clk);
        src_wr = src_rd;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        repeat (10) @(negedge clk);
        check("mid_no_bus", stb_total - stb_base, 0);
        check("mid_no_reply", rsp_n - rsp_base, 0);

        start_test();
        ws = 1; sl_rdata = 32'hCAFE_F00D;
        send(8'h02); send(8'h08); send(8'h00); send(8'h00); send(8'h00);
        wait_resp("post", 5);
        check("post_adr", sl_adr, 32'h0000_0008);
        check("post_stb_cycles", stb_total - stb_base, 2);
        check("post_b0", rb(0), 8'h00);
        check("post_b1", rb(1), 8'h0D);
        check("post_b4", rb(4), 8'hCA);

`ifdef WB_SERIAL_TIMEOUT_EN
        start_test();
        never_ack = 1;
        send(8'h02); send(8'h0C); send(8'h00); send(8'h00); send(8'h00);
        wait_resp("tmo", 5);
        check("tmo_stb_cycles", stb_total - stb_base, 16);
        check("tmo_b0", rb(0), 8'hEE);
        check("tmo_b1", rb(1), 8'h00);
        check("tmo_b4", rb(4), 8'h00);
        never_ack = 0;
`endif

        check("bus_stable", stab_err, 0);
        check("tx_stable", tx_stab_err, 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/wb_serial_master.md
Name: wb_serial_master

Overview:
- Byte-stream-to-Wishbone bridge and bus initiator: the other end of the register-access path.
- Consumes command bytes from the USB serial core's host-to-device pipe (uart_out_* style).
- Issues single classic Wishbone master cycles and returns status/read data on the device-to-host pipe (uart_in_* style).
- Lets the host peek/poke any Wishbone slave, including the USB serial slave's registers.

Parameters:
- AW, 32, Wishbone address width (1..32); address always travels as 4 bytes, upper bits truncated.
- DW, 32, Wishbone data width; fixed at 32, other values unsupported.
- TIMEOUT, 255, ack watchdog limit in cycles (used only with the optional feature).

Ports:
- wb_clk_i  in  1  single clock; all logic on rising edge.
- wb_reset_i  in  1  asynchronous, active-high reset.
- rx_data  in  8  incoming command byte; valid while rx_valid=1.
- rx_valid  in  1  rx_data holds an unconsumed byte.
- rx_get  out  1  one-cycle pulse that consumes rx_data.
- tx_data  out  8  outgoing response byte.
- tx_valid  out  1  tx_data valid; held until accepted.
- tx_ready  in  1  sink accepts when tx_valid&&tx_ready at a rising edge.
- wb_adr_o  out  AW  master address.
- wb_dat_o  out  DW  master write data.
- wb_dat_i  in  DW  slave read data.
- wb_we_o  out  1  write enable.
- wb_sel_o  out  DW/8  byte selects; constant all-ones.
- wb_cyc_o  out  1  cycle.
- wb_stb_o  out  1  strobe.
- wb_ack_i  in  1  slave acknowledge.

Behaviour:
- Protocol:
  - Write = 0x01, A0..A3, D0..D3 -> reply 1 byte: status.
  - Read = 0x02, A0..A3 -> reply 5 bytes: status, D0..D3.
  - All multi-byte fields little-endian (A0 = adr[7:0]).
  - Status codes: 0x00 OK, 0xEE timeout, 0xFF bad opcode.
- Reset (async): state IDLE, rx_get=0, tx_valid=0, tx_data=0, wb_cyc_o=wb_stb_o=wb_we_o=0, wb_adr_o=0, wb_dat_o=0. A partial command or in-flight bus cycle is abandoned; no reply is sent.
- rx_get is registered. It asserts for one cycle when rx_valid=1, the FSM is in a receiving state, and rx_get was 0 in the previous cycle. This gives a minimum 2-cycle spacing so the source can update rx_valid.
- States:
  - IDLE: takes opcode. 0x01/0x02 -> ADDR with byte counter=0. Any other value -> RESP with status 0xFF.
  - ADDR: shifts 4 bytes into the address. After the 4th byte: write -> DATA, read -> BUS.
  - DATA: shifts 4 bytes into wb_dat_o, then -> BUS.
  - BUS: wb_cyc_o=wb_stb_o=1 from the first cycle in BUS; wb_we_o=1 for writes. On wb_ack_i=1 at an edge: capture wb_dat_i (reads), drop cyc/stb/we on that same edge, status 0x00, go to RESP. A zero-wait-state slave therefore gives exactly 1 cycle of stb.
  - RESP: loads tx_data=status, tx_valid=1. Once accepted: write or 0xFF -> IDLE; read -> RDATA.
  - RDATA: presents D0..D3 in order. Each byte is held stable until tx_valid&&tx_ready. The next byte loads on the accepting edge, so back-to-back acceptance reaches 1 byte/cycle. tx_valid drops after D3 is accepted; -> IDLE.
- While in BUS/RESP/RDATA, rx_get stays 0 and rx bytes are left pending.
- wb_adr_o and wb_dat_o change only in ADDR/DATA, and are stable for the whole bus cycle.
- tx_ready held low indefinitely stalls the FSM with tx_data unchanged; there is no loss.

Optional Feature:
- Macro: WB_SERIAL_TIMEOUT_EN.
- Defined:
  - An 8+ bit counter clears on BUS entry and increments each BUS cycle without ack.
  - When it reaches TIMEOUT: drop cyc/stb/we, status 0xEE, -> RESP.
  - A read still returns 4 data bytes, all 0x00, so framing is preserved.
  - An ack arriving in the same cycle as expiry wins (status 0x00).
- Undefined: no counter; BUS waits forever for ack; 0xEE is never produced.

Decomposition:
- Package wb_serial_pkg:
  - Opcode constants OP_WRITE=0x01, OP_READ=0x02.
  - Status constants ST_OK=0x00, ST_TIMEOUT=0xEE, ST_BADOP=0xFF.
  - FSM state encoding (IDLE, ADDR, DATA, BUS, RESP, RDATA).
- Single flat module; no sub-module. The byte counter and shift registers are small enough to stay inline.

Test Plan:
- Write: send 01 10 00 00 00 EF BE AD DE with a slave acking in 0 wait states -> one cycle with adr=0x00000010, dat=0xDEADBEEF, we=1, sel=F, stb high exactly 1 cycle; reply 00.
- Read: send 02 04 00 00 00 with a slave returning 0x12345678 after 3 wait states -> cyc/stb held 4 cycles, we=0; reply 00 78 56 34 12.
- Bad opcode: send 7A -> reply FF, no Wishbone activity; following write command executes normally.
- Backpressure: a read with tx_ready toggling 1/0 per cycle and then held low 20 cycles -> each byte's tx_data stable while tx_valid, all 5 bytes delivered in order, none duplicated.
- Reset mid-command: assert wb_reset_i asynchronously after A1 of a write -> outputs at reset values immediately, no bus cycle, no reply; a fresh read then works.
- Timeout (WB_SERIAL_TIMEOUT_EN, TIMEOUT=16, slave never acks): send a read -> stb drops after 16 cycles; reply EE 00 00 00 00.
